// File: rtl/hydra_pkg.sv
// hydra_pkg: widths, header layout and tx FSM states shared by
// the hydra port transmitter and the switch-side header decoder.
package hydra_pkg;

   localparam int DATA_W = 16;
   localparam int LEN_W  = 9;
   localparam int PRIO_W = 3;
   localparam int PORT_W = 4;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [PRIO_W-1:0] prio;
      logic [PORT_W-1:0] dest;
   } hydra_hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOP,
      ST_HDR,
      ST_DATA,
      ST_EOP
   } tx_state_e;

   function automatic logic [DATA_W-1:0] hdr_pack(
      input hydra_hdr_t h
   );
      return {h.len, h.prio, h.dest};
   endfunction

endpackage

// File: rtl/hydra_port_tx.sv
// hydra_port_tx: frames descriptor + payload stream into the
// sop / header / payload / eop sequence of one hydra write port.
module hydra_port_tx
   import hydra_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              desc_vld,
   output logic              desc_rdy,
   input  logic [LEN_W-1:0]  desc_len,
   input  logic [PRIO_W-1:0] desc_prio,
   input  logic [PORT_W-1:0] desc_dest,
   input  logic              pl_vld,
   output logic              pl_rdy,
   input  logic [DATA_W-1:0] pl_data,
   input  logic              pause,
   output logic              wr_sop,
   output logic              wr_vld,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_eop,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt
);

   tx_state_e         r_state;
   hydra_hdr_t        r_hdr;
   logic [LEN_W-1:0]  r_rem;
   logic              r_sop;
   logic              r_vld;
   logic              r_eop;
   logic [DATA_W-1:0] r_data;
   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;

   hydra_hdr_t w_desc;
   logic       w_desc_hs;
   logic       w_pl_hs;

   assign w_desc = '{len: desc_len, prio: desc_prio, dest: desc_dest};

   // pause only holds off new packets; rst_n keeps accept low in reset
   assign desc_rdy = rst_n && !pause &&
                     (r_state == ST_IDLE || r_state == ST_EOP);
   assign pl_rdy   = (r_state == ST_HDR || r_state == ST_DATA) &&
                     (r_rem != '0);

   assign w_desc_hs = desc_vld & desc_rdy;
   assign w_pl_hs   = pl_vld & pl_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hdr   <= '0;
         r_rem   <= '0;
         r_sop   <= 1'b0;
         r_vld   <= 1'b0;
         r_eop   <= 1'b0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sop <= 1'b0;
         r_vld <= 1'b0;
         r_eop <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_EOP: begin
               if (w_desc_hs) begin
                  r_hdr   <= w_desc;
                  r_rem   <= desc_len;
                  r_sop   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_SOP;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SOP: begin
               r_vld   <= 1'b1;
               r_data  <= hdr_pack(r_hdr);
               r_state <= ST_HDR;
            end
            ST_HDR, ST_DATA: begin
               // rem==0 here means the last word is already on wr_data
               if (r_rem == '0) begin
                  r_eop   <= 1'b1;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= ST_EOP;
               end else begin
                  r_state <= ST_DATA;
                  if (w_pl_hs) begin
                     r_vld  <= 1'b1;
                     r_data <= pl_data;
                     r_rem  <= r_rem - LEN_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr_sop  = r_sop;
   assign wr_vld  = r_vld;
   assign wr_data = r_data;
   assign wr_eop  = r_eop;
   assign busy    = r_busy;
   assign pkt_cnt = r_cnt;

endmodule

// File: tb/tb_hydra_port_tx.sv
// tb_hydra_port_tx: directed vectors and corner-case sequences
// for the hydra port transmitter, checked against hand values.
module tb_hydra_port_tx;
   import hydra_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              desc_vld = 1'b0;
   logic              desc_rdy;
   logic [LEN_W-1:0]  desc_len = '0;
   logic [PRIO_W-1:0] desc_prio = '0;
   logic [PORT_W-1:0] desc_dest = '0;
   logic              pl_vld = 1'b0;
   logic              pl_rdy;
   logic [DATA_W-1:0] pl_data = '0;
   logic              pause = 1'b0;
   logic              wr_sop;
   logic              wr_vld;
   logic [DATA_W-1:0] wr_data;
   logic              wr_eop;
   logic              busy;
   logic [15:0]       pkt_cnt;

   hydra_port_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .desc_vld  (desc_vld),
      .desc_rdy  (desc_rdy),
      .desc_len  (desc_len),
      .desc_prio (desc_prio),
      .desc_dest (desc_dest),
      .pl_vld    (pl_vld),
      .pl_rdy    (pl_rdy),
      .pl_data   (pl_data),
      .pause     (pause),
      .wr_sop    (wr_sop),
      .wr_vld    (wr_vld),
      .wr_data   (wr_data),
      .wr_eop    (wr_eop),
      .busy      (busy),
      .pkt_cnt   (pkt_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // output monitor: frame events tagged with cycle numbers
   int          sop_q[$];
   int          eop_q[$];
   int          bub_q[$];
   logic [15:0] cnt_q[$];
   logic [15:0] data_q[$];
   bit          in_pkt = 1'b0;
   int          nb = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         sop_q.delete();
         eop_q.delete();
         bub_q.delete();
         cnt_q.delete();
         data_q.delete();
         in_pkt = 1'b0;
         nb = 0;
      end else if (wr_sop) begin
         sop_q.push_back(cyc);
         in_pkt = 1'b1;
         nb = 0;
      end else if (wr_eop) begin
         eop_q.push_back(cyc);
         cnt_q.push_back(pkt_cnt);
         bub_q.push_back(nb);
         in_pkt = 1'b0;
      end else if (wr_vld) begin
         data_q.push_back(wr_data);
      end else if (in_pkt) begin
         nb++;
      end
   end

   task automatic send(input int len, input int prio, input int dest,
                       input logic [15:0] base, input int bub_at,
                       input int bub_n, input int pause_at,
                       input int stop, output int t);
      int idx;
      int left;
      int g;
      bit hs;
      desc_len  = LEN_W'(len);
      desc_prio = PRIO_W'(prio);
      desc_dest = PORT_W'(dest);
      desc_vld  = 1'b1;
      hs = 1'b0;
      t = -1;
      for (int i = 0; i < 200 && !hs; i++) begin
         @(negedge clk);
         if (desc_rdy) begin
            hs = 1'b1;
            t = cyc;
         end
      end
      @(posedge clk);
      #1;
      desc_vld = 1'b0;
      if (!hs) begin
         n_chk++;
         $display("FAIL desc_hs: no accept in 200 cycles");
         return;
      end
      idx = 0;
      left = bub_n;
      g = 0;
      while (idx < stop && g < 3000) begin
         if (idx == pause_at) pause = 1'b1;
         if (idx == bub_at && left > 0) begin
            pl_vld = 1'b0;
            left--;
         end else begin
            pl_vld  = 1'b1;
            pl_data = base + 16'(idx);
         end
         @(negedge clk);
         if (pl_vld && pl_rdy) idx++;
         @(posedge clk);
         #1;
         g++;
      end
      pl_vld = 1'b0;
      if (idx < stop) begin
         n_chk++;
         $display("FAIL pl_stall: got %0d words want %0d", idx, stop);
      end
   endtask

   task automatic check_pkt(input string nm, input int t, input int len,
                            input logic [15:0] hdr,
                            input logic [15:0] base, input int eop_off,
                            input int bub, input int cnt,
                            output int sop_c, output int eop_c);
      int g;
      int errs;
      logic [15:0] w;
      g = 0;
      errs = 0;
      sop_c = -1;
      eop_c = -1;
      while (eop_q.size() == 0 && g < 1000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (eop_q.size() == 0 || sop_q.size() == 0) begin
         n_chk++;
         $display("FAIL %s_eop: got no frame want eop", nm);
         return;
      end
      sop_c = sop_q.pop_front();
      chk({nm, "_sop_cyc"}, sop_c - t, 1);
      w = (data_q.size() > 0) ? data_q.pop_front() : 16'hxxxx;
      chk({nm, "_hdr"}, w, hdr);
      for (int i = 0; i < len; i++) begin
         if (data_q.size() == 0) errs++;
         else if (data_q.pop_front() !== base + 16'(i)) errs++;
      end
      chk({nm, "_payload_errs"}, errs, 0);
      eop_c = eop_q.pop_front();
      chk({nm, "_eop_cyc"}, eop_c - t, eop_off);
      chk({nm, "_bubbles"}, bub_q.pop_front(), bub);
      chk({nm, "_pkt_cnt"}, cnt_q.pop_front(), cnt);
   endtask

   task automatic hold_off(input int n);
      int bad;
      bad = 0;
      desc_vld = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (desc_rdy || wr_sop || busy) bad++;
         @(posedge clk);
         #1;
      end
      chk("hold_off_bad_cycles", bad, 0);
   endtask

   typedef struct {
      int          len;
      int          prio;
      int          dest;
      logic [15:0] base;
      int          bub_at;
      int          bub_n;
      int          pause_at;
      logic [15:0] hdr;
      int          eop_off;
      int          cnt;
   } vec_t;

   vec_t vt[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t, t0, t1, t2;
      int s0, s1, s2, e0, e1, e2;

      vt[0] = '{31, 4, 3, 16'h0000, -1, 0, -1, 16'h0FC3, 34, 1};
      vt[1] = '{128, 2, 5, 16'h1000, -1, 0, 60, 16'h4025, 131, 2};
      vt[2] = '{8, 1, 9, 16'hA000, 4, 3, -1, 16'h0419, 14, 3};
      vt[3] = '{0, 7, 15, 16'h0000, -1, 0, -1, 16'h007F, 3, 4};
      vt[4] = '{1, 0, 0, 16'hBEEF, -1, 0, -1, 16'h0080, 4, 5};
      vt[5] = '{511, 5, 10, 16'h2000, -1, 0, -1, 16'hFFDA, 514, 6};

      desc_vld = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs",
          {wr_sop, wr_vld, wr_eop, busy, desc_rdy, pl_rdy,
           wr_data, pkt_cnt}, '0);
      desc_vld = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_desc_rdy", desc_rdy, 1);

      for (int k = 0; k < 6; k++) begin
         send(vt[k].len, vt[k].prio, vt[k].dest, vt[k].base,
              vt[k].bub_at, vt[k].bub_n, vt[k].pause_at,
              vt[k].len, t);
         check_pkt($sformatf("vec%0d", k), t, vt[k].len, vt[k].hdr,
                   vt[k].base, vt[k].eop_off, vt[k].bub_n,
                   vt[k].cnt, s0, e0);
         if (vt[k].pause_at >= 0) begin
            hold_off(10);
            desc_vld = 1'b0;
            pause = 1'b0;
         end
      end

      pause = 1'b1;
      desc_len  = 9'd4;
      desc_prio = 3'd6;
      desc_dest = 4'd2;
      hold_off(10);
      pause = 1'b0;
      send(4, 6, 2, 16'h5550, -1, 0, -1, 4, t);
      check_pkt("pausepend", t, 4, 16'h0262, 16'h5550, 7, 0, 7,
                s0, e0);

      send(20, 1, 1, 16'h7700, -1, 0, -1, 5, t);
      chk("mid_busy", busy, 1);
      chk("mid_no_eop", eop_q.size(), 0);
      desc_vld = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs",
          {wr_sop, wr_vld, wr_eop, busy, desc_rdy, pl_rdy,
           wr_data, pkt_cnt}, '0);
      repeat (3) @(posedge clk);
      #1;
      desc_vld = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_cnt", pkt_cnt, 0);

      send(55, 3, 3, 16'h3000, -1, 0, -1, 55, t0);
      send(55, 3, 3, 16'h4000, -1, 0, -1, 55, t1);
      send(54, 3, 3, 16'h5000, -1, 0, -1, 54, t2);
      check_pkt("b2b0", t0, 55, 16'h1BB3, 16'h3000, 58, 0, 1, s0, e0);
      check_pkt("b2b1", t1, 55, 16'h1BB3, 16'h4000, 58, 0, 2, s1, e1);
      check_pkt("b2b2", t2, 54, 16'h1B33, 16'h5000, 57, 0, 3, s2, e2);
      chk("b2b_gap01", s1 - e0, 1);
      chk("b2b_gap12", s2 - e1, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("final_idle_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
